// File: rtl/memory_arbiter_if.sv
// Bundle of the icache, dcache and RAM-side signals around the memory arbiter.
// The arbiter connects through the slave modport. The environment, meaning the
// caches plus the RAM, connects through the master modport. Passive observers
// use the monitor modport.
interface memory_arbiter_if;
   // icache side
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   // dcache side
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   // RAM side
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ram_ready;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
   );

   modport monitor (
      input iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN
   );
endinterface

// File: rtl/memory_arbiter.sv
// Memory arbiter. It merges icache and dcache word requests onto one RAM port.
// Every word takes one arbitration cycle in IDLE, followed by the RAM latency
// in DATA or INSTR.
//
// The dcache has priority. A saturating streak counter tracks consecutive data
// completions that occur while an instruction fetch is pending. Once the
// counter saturates, the next grant goes to the icache.
//
// Outputs are decoded combinationally from the registered state and the
// current inputs. This lets a wait signal drop in the same cycle that the RAM
// reports ready.
module memory_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input  logic              CLK,
   input  logic              RST,
   memory_arbiter_if.slave   bus
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX  = SW'(MAX_D_STREAK);
   localparam logic [SW-1:0] STREAK_ZERO = {SW{1'b0}};
   localparam logic [SW-1:0] STREAK_ONE  = SW'(1'b1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      INSTR = 2'd2
   } state_t;

   state_t        state_r;
   logic [SW-1:0] streak_r;

   logic data_req_s;
   logic streak_full_s;

   // Saturating increment of the data streak counter
   function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] value);
      if (value >= STREAK_MAX) begin
         return STREAK_MAX;
      end else begin
         return value + STREAK_ONE;
      end
   endfunction

   assign data_req_s    = bus.dREN | bus.dWEN;
   assign streak_full_s = (streak_r == STREAK_MAX);

   // Grant FSM and starvation counter.
   // A withdrawn request aborts the access and leaves the streak unchanged.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= IDLE;
         streak_r <= STREAK_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (data_req_s && !(bus.iREN && streak_full_s)) begin
                  state_r <= DATA;
               end else if (bus.iREN) begin
                  state_r <= INSTR;
               end else begin
                  state_r <= IDLE;
               end
            end
            DATA: begin
               if (!data_req_s) begin
                  state_r <= IDLE;
               end else if (bus.ram_ready) begin
                  state_r  <= IDLE;
                  streak_r <= bus.iREN ? streak_inc(streak_r) : STREAK_ZERO;
               end else begin
                  state_r <= DATA;
               end
            end
            INSTR: begin
               if (!bus.iREN) begin
                  state_r <= IDLE;
               end else if (bus.ram_ready) begin
                  state_r  <= IDLE;
                  streak_r <= STREAK_ZERO;
               end else begin
                  state_r <= INSTR;
               end
            end
            default: begin
               state_r  <= IDLE;
               streak_r <= STREAK_ZERO;
            end
         endcase
      end
   end

   // RAM strobes, address/data routing and wait/load decode for the granted requester
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'h0000_0000;
      bus.ramstore = 32'h0000_0000;
      bus.iload    = 32'h0000_0000;
      bus.dload    = 32'h0000_0000;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      case (state_r)
         IDLE: begin
            bus.ramREN = 1'b0;
         end
         DATA: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.dload    = bus.ramload;
            if (data_req_s) begin
               bus.ramWEN = bus.dWEN;
               bus.ramREN = bus.dREN & ~bus.dWEN;
               bus.dwait  = ~bus.ram_ready;
            end else begin
               bus.ramWEN = 1'b0;
               bus.ramREN = 1'b0;
               bus.dwait  = 1'b1;
            end
         end
         INSTR: begin
            bus.ramaddr = bus.iaddr;
            bus.iload   = bus.ramload;
            if (bus.iREN) begin
               bus.ramREN = 1'b1;
               bus.iwait  = ~bus.ram_ready;
            end else begin
               bus.ramREN = 1'b0;
               bus.iwait  = 1'b1;
            end
         end
         default: begin
            bus.ramREN = 1'b0;
         end
      endcase
   end

endmodule

// Protocol checker for the arbiter boundary.
// It is never synthesised as part of the datapath. Instantiate it next to the
// arbiter wherever the handshake should be watched.
module memory_arbiter_checker (
   input  logic               CLK,
   input  logic               RST,
   memory_arbiter_if.monitor  mon
);

   // Sample settled outputs between rising edges and flag illegal combinations
   always @(negedge CLK) begin
      if (!RST) begin
         assert (!(mon.ramREN && mon.ramWEN))
            else $error("FAIL chk_strobes: ramREN and ramWEN both high");
         assert (mon.iwait || mon.dwait)
            else $error("FAIL chk_waits: iwait and dwait low together");
         assert (mon.iwait || (mon.iREN && mon.ramREN))
            else $error("FAIL chk_iwait: iwait low without an active instruction read");
         assert (mon.dwait || ((mon.dREN || mon.dWEN) && (mon.ramREN || mon.ramWEN)))
            else $error("FAIL chk_dwait: dwait low without an active data access");
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter.
// Inputs change on the falling clock edge. Outputs are sampled 1 time unit
// later, well away from the rising edge where state updates.
module tb_memory_arbiter;

   logic CLK;
   logic RST;
   int   n_cmp;
   int   n_bad;

   memory_arbiter_if bus ();

   memory_arbiter #(.MAX_D_STREAK(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   memory_arbiter_checker u_chk (
      .CLK (CLK),
      .RST (RST),
      .mon (bus.monitor)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, i.e. one full clock after the previous one
   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".iwait"},  {31'd0, bus.iwait},  32'd1);
      chk({tag, ".dwait"},  {31'd0, bus.dwait},  32'd1);
      chk({tag, ".ramREN"}, {31'd0, bus.ramREN}, 32'd0);
      chk({tag, ".ramWEN"}, {31'd0, bus.ramWEN}, 32'd0);
   endtask

   // Run n cycles with the inputs held, comparing per-cycle expected bits (bit i = cycle i)
   task automatic run_pattern(input string tag, input int n,
                              input logic [15:0] exp_dw, input logic [15:0] exp_iw,
                              input logic [15:0] exp_wen, input logic [15:0] exp_ren);
      for (int i = 0; i < n; i++) begin
         cyc();
         #1;
         chk($sformatf("%s.dwait[%0d]", tag, i),  {31'd0, bus.dwait},  {31'd0, exp_dw[i]});
         chk($sformatf("%s.iwait[%0d]", tag, i),  {31'd0, bus.iwait},  {31'd0, exp_iw[i]});
         chk($sformatf("%s.ramWEN[%0d]", tag, i), {31'd0, bus.ramWEN}, {31'd0, exp_wen[i]});
         chk($sformatf("%s.ramREN[%0d]", tag, i), {31'd0, bus.ramREN}, {31'd0, exp_ren[i]});
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // Reset for 2 cycles with every request asserted
      RST           = 1'b1;
      bus.iREN      = 1'b1;
      bus.iaddr     = 32'h0000_0010;
      bus.dREN      = 1'b1;
      bus.dWEN      = 1'b1;
      bus.daddr     = 32'h0000_0020;
      bus.dstore    = 32'h0000_0030;
      bus.ramload   = 32'h1234_5678;
      bus.ram_ready = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1;
      chk_idle("reset");
      chk("reset.ramaddr",  bus.ramaddr,  32'h0);
      chk("reset.ramstore", bus.ramstore, 32'h0);
      chk("reset.iload",    bus.iload,    32'h0);
      chk("reset.dload",    bus.dload,    32'h0);

      // Data read: 0x100, RAM ready on the third DATA cycle
      RST           = 1'b0;
      bus.iREN      = 1'b0;
      bus.dWEN      = 1'b0;
      bus.dREN      = 1'b1;
      bus.daddr     = 32'h0000_0100;
      bus.ramload   = 32'hCAFE_BABE;
      bus.ram_ready = 1'b0;
      #1;
      chk_idle("rd_arb");
      cyc(); #1;
      chk("rd1.ramREN",  {31'd0, bus.ramREN}, 32'd1);
      chk("rd1.ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
      chk("rd1.ramaddr", bus.ramaddr, 32'h0000_0100);
      chk("rd1.dwait",   {31'd0, bus.dwait},  32'd1);
      cyc(); #1;
      chk("rd2.dwait",   {31'd0, bus.dwait},  32'd1);
      cyc();
      bus.ram_ready = 1'b1;
      #1;
      chk("rd3.dwait",   {31'd0, bus.dwait},  32'd0);
      chk("rd3.dload",   bus.dload, 32'hCAFE_BABE);
      chk("rd3.iwait",   {31'd0, bus.iwait},  32'd1);
      chk("rd3.iload",   bus.iload, 32'h0);

      // Contention: dREN and iREN rise together; data wins twice, then instr after dREN drops
      cyc();
      bus.ram_ready = 1'b0;
      bus.daddr     = 32'h0000_0200;
      bus.iREN      = 1'b1;
      bus.iaddr     = 32'h0000_0040;
      bus.ramload   = 32'h1111_1111;
      #1;
      chk_idle("ct_post_rd");
      chk("ct_post_rd.dload", bus.dload, 32'h0);
      cyc();
      bus.ram_ready = 1'b1;
      #1;
      chk("ct1.ramaddr", bus.ramaddr, 32'h0000_0200);
      chk("ct1.dwait",   {31'd0, bus.dwait}, 32'd0);
      chk("ct1.iwait",   {31'd0, bus.iwait}, 32'd1);
      chk("ct1.dload",   bus.dload, 32'h1111_1111);
      cyc();
      bus.ram_ready = 1'b0;
      #1;
      chk_idle("ct2_arb");
      cyc();
      bus.ram_ready = 1'b1;
      #1;
      chk("ct3.ramaddr", bus.ramaddr, 32'h0000_0200);
      chk("ct3.dwait",   {31'd0, bus.dwait}, 32'd0);
      chk("ct3.iwait",   {31'd0, bus.iwait}, 32'd1);
      cyc();
      bus.dREN      = 1'b0;
      bus.ram_ready = 1'b0;
      #1;
      chk_idle("ct4_arb");
      cyc();
      chk("ct5.ramaddr", bus.ramaddr, 32'h0000_0040);
      chk("ct5.ramREN",  {31'd0, bus.ramREN}, 32'd1);
      chk("ct5.iwait_busy", {31'd0, bus.iwait}, 32'd1);
      bus.ramload   = 32'h2222_2222;
      bus.ram_ready = 1'b1;
      #1;
      chk("ct5.iwait",   {31'd0, bus.iwait}, 32'd0);
      chk("ct5.iload",   bus.iload, 32'h2222_2222);
      chk("ct5.dwait",   {31'd0, bus.dwait}, 32'd1);
      chk("ct5.dload",   bus.dload, 32'h0);

      // Starvation: writes held with iREN high; 4 data words, 1 instr word, then data again
      cyc();
      bus.dWEN      = 1'b1;
      bus.daddr     = 32'h0000_3000;
      bus.dstore    = 32'h0000_00A5;
      bus.iREN      = 1'b1;
      bus.iaddr     = 32'h0000_0080;
      bus.ram_ready = 1'b1;
      #1;
      chk_idle("sv_arb");
      run_pattern("starve", 11, 16'h03AA, 16'h06FF, 16'h0455, 16'h0100);

      // Withdrawal: dREN drops mid DATA with ram_ready high; streak stays at 1
      cyc();
      bus.dWEN      = 1'b0;
      bus.dREN      = 1'b1;
      bus.daddr     = 32'h0000_0300;
      bus.ram_ready = 1'b0;
      #1;
      chk_idle("wd_arb");
      cyc(); #1;
      chk("wd1.ramREN",  {31'd0, bus.ramREN}, 32'd1);
      chk("wd1.ramaddr", bus.ramaddr, 32'h0000_0300);
      cyc();
      bus.dREN      = 1'b0;
      bus.ram_ready = 1'b1;
      #1;
      chk("wd2.dwait",  {31'd0, bus.dwait},  32'd1);
      chk("wd2.ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("wd2.iwait",  {31'd0, bus.iwait},  32'd1);
      cyc(); #1;
      chk_idle("wd3");
      // Streak of 1 means 3 more data words before the forced instruction grant
      bus.dREN = 1'b1;
      run_pattern("wd_streak", 7, 16'h006A, 16'h003F, 16'h0000, 16'h0055);

      // dREN and dWEN together: write wins
      cyc();
      bus.iREN      = 1'b0;
      bus.dREN      = 1'b1;
      bus.dWEN      = 1'b1;
      bus.daddr     = 32'h0000_3100;
      bus.dstore    = 32'h0000_0005;
      bus.ram_ready = 1'b0;
      #1;
      chk_idle("rw_arb");
      cyc();
      bus.ram_ready = 1'b1;
      #1;
      chk("rw.ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
      chk("rw.ramREN",   {31'd0, bus.ramREN}, 32'd0);
      chk("rw.ramstore", bus.ramstore, 32'h0000_0005);
      chk("rw.ramaddr",  bus.ramaddr,  32'h0000_3100);
      chk("rw.dwait",    {31'd0, bus.dwait}, 32'd0);

      // Reset mid instruction access; ram_ready in IDLE is ignored afterwards
      cyc();
      bus.dREN      = 1'b0;
      bus.dWEN      = 1'b0;
      bus.iREN      = 1'b1;
      bus.iaddr     = 32'h0000_0044;
      bus.ram_ready = 1'b0;
      #1;
      chk_idle("mr_arb");
      cyc(); #1;
      chk("mr1.ramREN",  {31'd0, bus.ramREN}, 32'd1);
      chk("mr1.ramaddr", bus.ramaddr, 32'h0000_0044);
      RST = 1'b1;
      cyc();
      RST           = 1'b0;
      bus.ram_ready = 1'b1;
      #1;
      chk_idle("mr2");
      chk("mr2.ramaddr", bus.ramaddr, 32'h0);
      cyc();
      bus.ramload = 32'h3333_3333;
      #1;
      chk("mr3.iwait", {31'd0, bus.iwait}, 32'd0);
      chk("mr3.iload", bus.iload, 32'h3333_3333);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
